wr_burst_sched: RTL and testbench
=================================

WR_BURST_SCHED -- requirements
Module: wr_burst_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 64, beat width of FIFO read data and burst write data.
REQ-002 Parameter CNT_WIDTH, default 8, width of each channel's rd_data_count input.
REQ-003 Parameter ADDR_WIDTH, default 30, byte-address width of the burst address.
REQ-004 Parameter BURST_LEN, default 16, beats per write burst (range 2..256).
REQ-005 Parameters CH0_BASE/CH0_END, defaults 0x0000/0x0400; CH1_BASE/CH1_END, defaults 0x1000/0x1400; per-channel byte-address region [BASE, END).
REQ-006 axi_clk  in  1  sole clock; all logic on rising edge.
REQ-007 axi_rst  in  1  reset, synchronous, active-high.
REQ-008 ch0_rd_data_count, ch1_rd_data_count  in  CNT_WIDTH  words available in each channel's write FIFO.
REQ-009 ch0_rd_data, ch1_rd_data  in  DATA_WIDTH  FIFO head word (first-word-fall-through).
REQ-010 ch0_fifo_rd_en, ch1_fifo_rd_en  out  1  pops one word from that FIFO.
REQ-011 wr_burst_req  out  1; wr_burst_addr  out  ADDR_WIDTH; wr_burst_len  out  8 (= BURST_LEN-1); wr_burst_ack  in  1; burst request handshake to the AXI master.
REQ-012 wr_data_req  in  1  master takes one beat this cycle; wr_data  out  DATA_WIDTH  beat data; wr_burst_done  in  1  burst response received.
REQ-013 busy  out  1; active_ch  out  1  granted channel.
REQ-014 ch0_burst_cnt, ch1_burst_cnt  out  32  completed-burst statistics.

Function
REQ-015 Channel eligible when its rd_data_count >= BURST_LEN; count of BURST_LEN-1 SHALL NOT be eligible.
REQ-016 FSM states IDLE, REQ, DATA, WAIT_DONE; IDLE->REQ when any channel eligible, grant latched in same cycle.
REQ-017 Both eligible: round-robin, channel not granted last wins; after reset ch0 wins first tie.
REQ-018 REQ: wr_burst_req held high, addr/len stable, until wr_burst_ack sampled high; then DATA next cycle.
REQ-019 DATA: granted chX_fifo_rd_en = wr_data_req, combinational, zero latency; wr_data = granted chX_rd_data; other channel's rd_en SHALL be 0.
REQ-020 Beat counter counts accepted beats; after BURST_LEN-th beat go WAIT_DONE; wr_data_req outside DATA SHALL NOT pop any FIFO.
REQ-021 WAIT_DONE: on wr_burst_done advance granted channel address by BURST_LEN*DATA_WIDTH/8; if result >= CHx_END, load CHx_BASE (wrap); return to IDLE.
REQ-022 wr_burst_done outside WAIT_DONE SHALL be ignored.
REQ-023 busy high in every state except IDLE; active_ch valid while busy.

Reset
REQ-024 On axi_rst: state IDLE, addresses = CHx_BASE, beat counter 0, round-robin pointer favours ch0, all outputs 0 (wr_burst_addr = CH0_BASE), counters 0.
REQ-025 Reset asserted mid-burst SHALL abandon the burst at the next edge with no further FIFO pops.

Configuration
REQ-026 Macro WR_SCHED_STAT_EN defined: chX_burst_cnt increments by 1 on each REQ-021 completion of channel X, wraps at 2^32.
REQ-027 Macro undefined: chX_burst_cnt ports present, driven constant 0, no counter logic.

Structure
REQ-028 Package wr_sched_pkg SHALL hold the FSM state enum and the beat-bytes constant.
REQ-029 Sub-module rr_arb2 SHALL implement two-requester round-robin arbitration with grant-update strobe.

Verification
REQ-030 ch0 count 16, ch1 0 -> req with addr 0x000, len 15; 16 ch0 pops, zero ch1 pops; after done ch0 addr 0x080.
REQ-031 Both counts 20 from reset -> grant order ch0, ch1, ch0; addresses 0x000, 0x1000, 0x080.
REQ-032 ch0 count 15 -> wr_burst_req stays 0, busy 0 for 100 cycles.
REQ-033 Eight ch0 bursts -> ninth uses addr 0x000 (wrap at 0x400); with WR_SCHED_STAT_EN ch0_burst_cnt = 9 after ninth done, without it 0.
REQ-034 wr_burst_ack held low 10 cycles -> req and addr stable throughout, no pops; extra wr_data_req after 16th beat -> no pop.
REQ-035 axi_rst after 5 beats -> next cycle IDLE, rd_en 0, ch0 addr 0x000.

Source files
------------

// File: rtl/wr_sched_pkg.sv
// Shared types and constants for the write-burst scheduler.
package wr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_DATA      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int unsigned BYTE_BITS = 8;

  // Bytes carried by one beat of the given data width
  function automatic int unsigned beat_bytes(input int unsigned data_width);
    return data_width / BYTE_BITS;
  endfunction

endpackage

// File: rtl/wr_burst_sched_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips to the loser when i_update strobes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_gnt_vld_c,
  output logic       o_gnt_idx_c
);

  logic r_prio;

  always_comb begin
    o_gnt_vld_c = |i_req;
    o_gnt_idx_c = 1'b0;
    if (i_req == 2'b11) o_gnt_idx_c = r_prio;
    else                o_gnt_idx_c = i_req[1];
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_prio <= 1'b0;
    else if (i_update && o_gnt_vld_c) r_prio <= ~o_gnt_idx_c;
  end

endmodule

// File: rtl/wr_burst_sched.sv
// Schedules fixed-length AXI write bursts from two FWFT FIFOs into per-channel address rings.
// Optional macro WR_SCHED_STAT_EN enables the per-channel completed-burst counters.
module wr_burst_sched
  import wr_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CH0_BASE   = 32'h0000_0000,
  parameter int unsigned CH0_END    = 32'h0000_0400,
  parameter int unsigned CH1_BASE   = 32'h0000_1000,
  parameter int unsigned CH1_END    = 32'h0000_1400
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic [CNT_WIDTH-1:0]  ch0_rd_data_count,
  input  logic [CNT_WIDTH-1:0]  ch1_rd_data_count,
  input  logic [DATA_WIDTH-1:0] ch0_rd_data,
  input  logic [DATA_WIDTH-1:0] ch1_rd_data,
  output logic                  ch0_fifo_rd_en,
  output logic                  ch1_fifo_rd_en,
  output logic                  wr_burst_req,
  output logic [ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [7:0]            wr_burst_len,
  input  logic                  wr_burst_ack,
  input  logic                  wr_data_req,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_burst_done,
  output logic                  busy,
  output logic                  active_ch,
  output logic [31:0]           ch0_burst_cnt,
  output logic [31:0]           ch1_burst_cnt
);

  localparam int unsigned BEAT_W      = $clog2(BURST_LEN);
  localparam int unsigned CMP_W       = CNT_WIDTH + 9;
  localparam int unsigned AW1         = ADDR_WIDTH + 1;
  localparam int unsigned BURST_BYTES = beat_bytes(DATA_WIDTH) * BURST_LEN;

  state_e                r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic [ADDR_WIDTH-1:0] r_ch0_addr;
  logic [ADDR_WIDTH-1:0] r_ch1_addr;

  logic                  w_ch0_elig;
  logic                  w_ch1_elig;
  logic                  w_gnt_vld;
  logic                  w_gnt_idx;
  logic                  w_pop;
  logic [AW1-1:0]        w_ch0_sum;
  logic [AW1-1:0]        w_ch1_sum;
  logic [ADDR_WIDTH-1:0] w_ch0_next;
  logic [ADDR_WIDTH-1:0] w_ch1_next;

  assign w_ch0_elig = CMP_W'(ch0_rd_data_count) >= CMP_W'(BURST_LEN);
  assign w_ch1_elig = CMP_W'(ch1_rd_data_count) >= CMP_W'(BURST_LEN);

  rr_arb2 u_arb (
    .clk         (axi_clk),
    .rst         (axi_rst),
    .i_req       ({w_ch1_elig, w_ch0_elig}),
    .i_update    (r_state == ST_IDLE),
    .o_gnt_vld_c (w_gnt_vld),
    .o_gnt_idx_c (w_gnt_idx)
  );

  // Extra MSB on the sum keeps the wrap compare correct near the top of the address space
  assign w_ch0_sum  = {1'b0, r_ch0_addr} + AW1'(BURST_BYTES);
  assign w_ch1_sum  = {1'b0, r_ch1_addr} + AW1'(BURST_BYTES);
  assign w_ch0_next = (w_ch0_sum >= AW1'(CH0_END)) ? ADDR_WIDTH'(CH0_BASE) : w_ch0_sum[ADDR_WIDTH-1:0];
  assign w_ch1_next = (w_ch1_sum >= AW1'(CH1_END)) ? ADDR_WIDTH'(CH1_BASE) : w_ch1_sum[ADDR_WIDTH-1:0];

  // Zero-latency pop path; reset blocks pops in the cycle it is asserted
  assign w_pop          = (r_state == ST_DATA) && wr_data_req && !axi_rst;
  assign ch0_fifo_rd_en = w_pop && !active_ch;
  assign ch1_fifo_rd_en = w_pop && active_ch;
  assign wr_data        = active_ch ? ch1_rd_data : ch0_rd_data;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      r_state       <= ST_IDLE;
      r_beat        <= '0;
      r_ch0_addr    <= ADDR_WIDTH'(CH0_BASE);
      r_ch1_addr    <= ADDR_WIDTH'(CH1_BASE);
      wr_burst_req  <= 1'b0;
      wr_burst_addr <= ADDR_WIDTH'(CH0_BASE);
      wr_burst_len  <= 8'd0;
      busy          <= 1'b0;
      active_ch     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_state       <= ST_REQ;
            active_ch     <= w_gnt_idx;
            busy          <= 1'b1;
            wr_burst_req  <= 1'b1;
            wr_burst_addr <= w_gnt_idx ? r_ch1_addr : r_ch0_addr;
            wr_burst_len  <= 8'(BURST_LEN - 1);
          end
        end
        ST_REQ: begin
          if (wr_burst_ack) begin
            wr_burst_req <= 1'b0;
            r_beat       <= '0;
            r_state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr_data_req) begin
            if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
              r_beat  <= '0;
              r_state <= ST_WAIT_DONE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (wr_burst_done) begin
            if (active_ch) r_ch1_addr <= w_ch1_next;
            else           r_ch0_addr <= w_ch0_next;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef WR_SCHED_STAT_EN
  logic w_done;
  assign w_done = (r_state == ST_WAIT_DONE) && wr_burst_done;

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      ch0_burst_cnt <= 32'd0;
      ch1_burst_cnt <= 32'd0;
    end else if (w_done) begin
      if (active_ch) ch1_burst_cnt <= ch1_burst_cnt + 32'd1;
      else           ch0_burst_cnt <= ch0_burst_cnt + 32'd1;
    end
  end
`else
  assign ch0_burst_cnt = 32'd0;
  assign ch1_burst_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wr_burst_sched.sv
// Scoreboard bench for wr_burst_sched: expected bursts queued by stimulus, checked by a request monitor.
module tb_wr_burst_sched;

  logic        axi_clk = 1'b0;
  logic        axi_rst;
  logic [7:0]  ch0_rd_data_count, ch1_rd_data_count;
  logic [63:0] ch0_rd_data, ch1_rd_data;
  logic        ch0_fifo_rd_en, ch1_fifo_rd_en;
  logic        wr_burst_req;
  logic [29:0] wr_burst_addr;
  logic [7:0]  wr_burst_len;
  logic        wr_burst_ack, wr_data_req, wr_burst_done;
  logic [63:0] wr_data;
  logic        busy, active_ch;
  logic [31:0] ch0_burst_cnt, ch1_burst_cnt;

  always #5 axi_clk = ~axi_clk;

  wr_burst_sched dut (
    .axi_clk           (axi_clk),
    .axi_rst           (axi_rst),
    .ch0_rd_data_count (ch0_rd_data_count),
    .ch1_rd_data_count (ch1_rd_data_count),
    .ch0_rd_data       (ch0_rd_data),
    .ch1_rd_data       (ch1_rd_data),
    .ch0_fifo_rd_en    (ch0_fifo_rd_en),
    .ch1_fifo_rd_en    (ch1_fifo_rd_en),
    .wr_burst_req      (wr_burst_req),
    .wr_burst_addr     (wr_burst_addr),
    .wr_burst_len      (wr_burst_len),
    .wr_burst_ack      (wr_burst_ack),
    .wr_data_req       (wr_data_req),
    .wr_data           (wr_data),
    .wr_burst_done     (wr_burst_done),
    .busy              (busy),
    .active_ch         (active_ch),
    .ch0_burst_cnt     (ch0_burst_cnt),
    .ch1_burst_cnt     (ch1_burst_cnt)
  );

  // FWFT FIFO model: head word encodes channel tag and number of words already popped
  int unsigned pop0 = 0;
  int unsigned pop1 = 0;
  assign ch0_rd_data = {32'hC0C0C0C0, pop0};
  assign ch1_rd_data = {32'hC1C1C1C1, pop1};
  always @(posedge axi_clk) begin
    if (ch0_fifo_rd_en) pop0 <= pop0 + 1;
    if (ch1_fifo_rd_en) pop1 <= pop1 + 1;
  end

  typedef struct {
    logic        ch;
    logic [29:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every new burst request is compared against the oldest queued expectation
  always @(negedge axi_clk) begin
    if (wr_burst_req && !mon_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual_addr=0x%0h actual_ch=%0d", wr_burst_addr, active_ch);
      end else begin
        mon_e = exp_q.pop_front();
        check("req_addr", 64'(wr_burst_addr), 64'(mon_e.addr));
        check("req_ch",   64'(active_ch),     64'(mon_e.ch));
        check("req_len",  64'(wr_burst_len),  64'd15);
        check("req_busy", 64'(busy),          64'd1);
      end
    end
    mon_prev = wr_burst_req;
  end

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_burst_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_req timeout actual=0 required=1");
    end
  endtask

  task automatic do_reset();
    axi_rst = 1'b1;
    tick();
    tick();
    axi_rst = 1'b0;
  endtask

  // Master model for one burst; stop zeroes both counts once the burst is accepted
  task automatic run_burst(input logic ch, input int ack_delay, input bit extra, input bit stop);
    bit          ok;
    logic [29:0] a;
    int unsigned p0, p1;
    wait_req(ok);
    if (!ok) return;
    a  = wr_burst_addr;
    p0 = pop0;
    p1 = pop1;
    for (int i = 0; i < ack_delay; i++) begin
      wr_burst_done = (i == 2);
      wr_data_req   = (i == 4);
      tick();
      wr_burst_done = 1'b0;
      wr_data_req   = 1'b0;
      check("req_hold",    64'(wr_burst_req),  64'd1);
      check("addr_stable", 64'(wr_burst_addr), 64'(a));
    end
    if (ack_delay > 0) check("pop_in_req", 64'(pop0 + pop1), 64'(p0 + p1));
    wr_burst_ack = 1'b1;
    tick();
    wr_burst_ack = 1'b0;
    check("req_drop", 64'(wr_burst_req), 64'd0);
    if (stop) begin
      ch0_rd_data_count = 8'd0;
      ch1_rd_data_count = 8'd0;
    end
    for (int b = 0; b < 16; b++) begin
      wr_data_req = 1'b1;
      #1;
      check("wr_data", wr_data, ch ? {32'hC1C1C1C1, pop1} : {32'hC0C0C0C0, pop0});
      check("rd_en_other", 64'(ch ? ch0_fifo_rd_en : ch1_fifo_rd_en), 64'd0);
      tick();
    end
    wr_data_req = 1'b0;
    if (extra) begin
      wr_data_req = 1'b1;
      #1;
      check("extra_pop", 64'(ch0_fifo_rd_en | ch1_fifo_rd_en), 64'd0);
      tick();
      wr_data_req = 1'b0;
    end
    check("pops_granted", 64'(ch ? pop1 - p1 : pop0 - p0), 64'd16);
    check("pops_other",   64'(ch ? pop0 - p0 : pop1 - p1), 64'd0);
    wr_burst_done = 1'b1;
    tick();
    wr_burst_done = 1'b0;
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    bit          ok;
    bit          seen;
    int unsigned p0, p1;
    axi_rst           = 1'b1;
    ch0_rd_data_count = 8'd0;
    ch1_rd_data_count = 8'd0;
    wr_burst_ack      = 1'b0;
    wr_data_req       = 1'b0;
    wr_burst_done     = 1'b0;
    tick();
    tick();
    tick();
    check("rst_busy",   64'(busy),          64'd0);
    check("rst_req",    64'(wr_burst_req),  64'd0);
    check("rst_addr",   64'(wr_burst_addr), 64'h0);
    check("rst_len",    64'(wr_burst_len),  64'd0);
    check("rst_ch",     64'(active_ch),     64'd0);
    check("rst_rd_en",  64'({ch1_fifo_rd_en, ch0_fifo_rd_en}), 64'd0);
    check("rst_cnt0",   64'(ch0_burst_cnt), 64'd0);
    check("rst_cnt1",   64'(ch1_burst_cnt), 64'd0);
    axi_rst = 1'b0;

    // One word short of a burst must never start one
    ch0_rd_data_count = 8'd15;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen = seen | wr_burst_req | busy;
    end
    check("below_len_idle", 64'(seen), 64'd0);

    // Single ch0 burst with delayed ack, stray done and extra data request, then address advance
    exp_q.push_back('{1'b0, 30'h000});
    ch0_rd_data_count = 8'd16;
    run_burst(1'b0, 10, 1'b1, 1'b0);
    exp_q.push_back('{1'b0, 30'h080});
    run_burst(1'b0, 0, 1'b0, 1'b1);
    repeat (5) tick();

    // Round-robin from reset with both channels eligible
    do_reset();
    exp_q.push_back('{1'b0, 30'h0000});
    exp_q.push_back('{1'b1, 30'h1000});
    exp_q.push_back('{1'b0, 30'h0080});
    ch0_rd_data_count = 8'd20;
    ch1_rd_data_count = 8'd20;
    run_burst(1'b0, 0, 1'b0, 1'b0);
    run_burst(1'b1, 0, 1'b0, 1'b0);
    run_burst(1'b0, 0, 1'b0, 1'b1);
    repeat (5) tick();

    // Address ring wrap after eight bursts, plus statistics
    do_reset();
    for (int k = 0; k < 9; k++) exp_q.push_back('{1'b0, (k < 8) ? 30'(k * 128) : 30'h0});
    ch0_rd_data_count = 8'd16;
    for (int k = 0; k < 9; k++) run_burst(1'b0, 0, 1'b0, k == 8);
`ifdef WR_SCHED_STAT_EN
    check("stat_cnt0", 64'(ch0_burst_cnt), 64'd9);
`else
    check("stat_cnt0", 64'(ch0_burst_cnt), 64'd0);
`endif
    check("stat_cnt1", 64'(ch1_burst_cnt), 64'd0);
    repeat (5) tick();

    // Reset in the middle of a burst
    do_reset();
    exp_q.push_back('{1'b0, 30'h000});
    ch0_rd_data_count = 8'd16;
    wait_req(ok);
    wr_burst_ack = 1'b1;
    tick();
    wr_burst_ack = 1'b0;
    for (int b = 0; b < 5; b++) begin
      wr_data_req = 1'b1;
      tick();
    end
    p0 = pop0;
    p1 = pop1;
    axi_rst = 1'b1;
    #1;
    check("rst_mid_rd_en", 64'({ch1_fifo_rd_en, ch0_fifo_rd_en}), 64'd0);
    tick();
    check("rst_mid_busy", 64'(busy),         64'd0);
    check("rst_mid_req",  64'(wr_burst_req), 64'd0);
    check("rst_mid_pops", 64'(pop0 + pop1),  64'(p0 + p1));
    wr_data_req = 1'b0;
    exp_q.push_back('{1'b0, 30'h000});
    axi_rst = 1'b0;
    run_burst(1'b0, 0, 1'b0, 1'b1);
    repeat (5) tick();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
